// File: rtl/sponge_absorb.sv
// sponge_absorb: absorb phase of a sponge construction. Message words are XORed
// into the rate register, each block goes through an external permutation, and the
// final block is padded (10* style, single 1 bit after the message). When the last
// permutation returns, the rate/capacity state is presented for the squeeze stage.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   start, msg_len        begin a message of msg_len bits (accepted in IDLE only)
//   in_valid/in_data      MSB-first message words; in_ready high only in ABSORB
//   perm_go/perm_r/perm_c permutation request, held with stable operands until done
//   perm_done/perm_rin/perm_cin  permutation result
//   r_out/c_out           final state, valid from the absorb_done pulse onward
//   absorb_done           one-cycle completion pulse
//   busy                  high whenever not in IDLE
module sponge_absorb #(
    parameter int unsigned RWIDTH   = 32,
    parameter int unsigned CWIDTH   = 320,
    parameter int unsigned LENWIDTH = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LENWIDTH-1:0] msg_len,
    input  logic                in_valid,
    input  logic [RWIDTH-1:0]   in_data,
    output logic                in_ready,
    output logic                perm_go,
    output logic [RWIDTH-1:0]   perm_r,
    output logic [CWIDTH-1:0]   perm_c,
    input  logic                perm_done,
    input  logic [RWIDTH-1:0]   perm_rin,
    input  logic [CWIDTH-1:0]   perm_cin,
    output logic [RWIDTH-1:0]   r_out,
    output logic [CWIDTH-1:0]   c_out,
    output logic                absorb_done,
    output logic                busy
);

    typedef enum logic [2:0] {StIdle, StAbsorb, StPad, StPermute, StDone} state_e;

    localparam logic [LENWIDTH-1:0] RwLen  = LENWIDTH'(RWIDTH);
    localparam logic [RWIDTH-1:0]   MsbBit = {1'b1, {(RWIDTH-1){1'b0}}};
    localparam logic [RWIDTH-1:0]   AllOnes = {RWIDTH{1'b1}};

    state_e              state_q, state_d;
    logic [LENWIDTH-1:0] rem_q, rem_d;
    logic                final_q, final_d;
    logic [RWIDTH-1:0]   rate_q, rate_d;
    logic [CWIDTH-1:0]   cap_q, cap_d;
    logic [RWIDTH-1:0]   r_out_q, r_out_d;
    logic [CWIDTH-1:0]   c_out_q, c_out_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            rem_q   <= '0;
            final_q <= 1'b0;
            rate_q  <= '0;
            cap_q   <= '0;
            r_out_q <= '0;
            c_out_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            final_q <= final_d;
            rate_q  <= rate_d;
            cap_q   <= cap_d;
            r_out_q <= r_out_d;
            c_out_q <= c_out_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        final_d = final_q;
        rate_d  = rate_q;
        cap_d   = cap_q;
        r_out_d = r_out_q;
        c_out_d = c_out_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d   = msg_len;
                    rate_d  = '0;
                    cap_d   = '0;
                    final_d = 1'b0;
                    state_d = (msg_len != '0) ? StAbsorb : StPad;
                end
            end
            StAbsorb: begin
                if (in_valid) begin
                    if (rem_q >= RwLen) begin
                        rate_d = rate_q ^ in_data;
                        rem_d  = rem_q - RwLen;
                    end else begin
                        // Keep the top rem bits of the word, then the pad bit right after.
                        rate_d  = rate_q ^ ((in_data & ~(AllOnes >> rem_q)) | (MsbBit >> rem_q));
                        rem_d   = '0;
                        final_d = 1'b1;
                    end
                    state_d = StPermute;
                end
            end
            StPad: begin
                rate_d  = rate_q ^ MsbBit;
                final_d = 1'b1;
                state_d = StPermute;
            end
            StPermute: begin
                if (perm_done) begin
                    rate_d = perm_rin;
                    cap_d  = perm_cin;
                    if (final_q) begin
                        // Load outputs on entry so they are valid during absorb_done.
                        r_out_d = perm_rin;
                        c_out_d = perm_cin;
                        state_d = StDone;
                    end else if (rem_q != '0) begin
                        state_d = StAbsorb;
                    end else begin
                        state_d = StPad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        in_ready    = (state_q == StAbsorb);
        perm_go     = (state_q == StPermute);
        absorb_done = (state_q == StDone);
        busy        = (state_q != StIdle);
    end

    assign perm_r = rate_q;
    assign perm_c = cap_q;
    assign r_out  = r_out_q;
    assign c_out  = c_out_q;

endmodule

// File: tb/tb_sponge_absorb.sv
module tb_sponge_absorb;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [19:0]  msg_len = '0;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = '0;
    logic         in_ready;
    logic         perm_go;
    logic [31:0]  perm_r;
    logic [319:0] perm_c;
    logic         perm_done;
    logic [31:0]  perm_rin;
    logic [319:0] perm_cin;
    logic [31:0]  r_out;
    logic [319:0] c_out;
    logic         absorb_done;
    logic         busy;

    int tests = 0;
    int fails = 0;

    sponge_absorb dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .msg_len     (msg_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .perm_go     (perm_go),
        .perm_r      (perm_r),
        .perm_c      (perm_c),
        .perm_done   (perm_done),
        .perm_rin    (perm_rin),
        .perm_cin    (perm_cin),
        .r_out       (r_out),
        .c_out       (c_out),
        .absorb_done (absorb_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Stub permutation: result 3 cycles after perm_go rises.
    logic [1:0] stub_cnt;
    always @(posedge clk) begin
        if (reset) begin
            stub_cnt  <= 2'd0;
            perm_done <= 1'b0;
        end else begin
            perm_done <= 1'b0;
            if (perm_go && !perm_done) begin
                if (stub_cnt == 2'd2) begin
                    perm_done <= 1'b1;
                    perm_rin  <= perm_r ^ 32'hFFFF_FFFF;
                    perm_cin  <= perm_c + 320'd1;
                    stub_cnt  <= 2'd0;
                end else begin
                    stub_cnt <= stub_cnt + 2'd1;
                end
            end else begin
                stub_cnt <= 2'd0;
            end
        end
    end

    // Event monitors; tests read snapshots and compare differences.
    int          perm_rises = 0;
    int          words_acc = 0;
    int          done_pulses = 0;
    int          ready_in_perm = 0;
    int          unstable = 0;
    logic        go_prev = 1'b0;
    logic [31:0] r_prev = '0;
    logic [31:0] perm_log [8];
    always @(posedge clk) begin
        go_prev <= perm_go;
        r_prev  <= perm_r;
        if (perm_go && !go_prev) begin
            perm_log[perm_rises % 8] <= perm_r;
            perm_rises <= perm_rises + 1;
        end
        if (perm_go && go_prev && perm_r !== r_prev) unstable <= unstable + 1;
        if (in_valid && in_ready) words_acc <= words_acc + 1;
        if (absorb_done) done_pulses <= done_pulses + 1;
        if (perm_go && in_ready) ready_in_perm <= ready_in_perm + 1;
    end

    // Runs one message; entered and left at #1 after a rising edge.
    task automatic do_msg(input logic [19:0] len, input logic [31:0] w0, input logic [31:0] w1,
                          input int nw, input int gap, input bit disturb,
                          output logic [31:0] r, output logic [319:0] c,
                          output int lat, output bit tmo);
        int n;
        tmo = 1'b0;
        msg_len = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (disturb) msg_len = 20'd8;
        for (int i = 0; i < nw; i++) begin
            for (int g = 0; g < gap; g++) begin
                start = disturb;
                @(posedge clk); #1;
            end
            start = 1'b0;
            in_valid = 1'b1;
            in_data = (i == 0) ? w0 : w1;
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            if (!in_ready) tmo = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data = 32'hDEAD_BEEF;
        end
        n = 0;
        while (!absorb_done && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!absorb_done) tmo = 1'b1;
        lat = n;
        r = r_out;
        c = c_out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        tests++; if (perm_go !== 1'b0) begin fails++; $display("FAIL reset_perm_go got %b want 0", perm_go); end
        tests++; if (absorb_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", absorb_done); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (r_out !== 32'd0) begin fails++; $display("FAIL reset_r_out got %h want 0", r_out); end
        tests++; if (c_out !== 320'd0) begin fails++; $display("FAIL reset_c_out got %h want 0", c_out); end
    endtask

    task automatic test_empty();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int bp, bw, bd;
        bp = perm_rises; bw = words_acc; bd = done_pulses;
        in_valid = 1'b1;
        in_data = 32'hFFFF_FFFF;
        do_msg(20'd0, 32'h0, 32'h0, 0, 0, 1'b0, r, c, lat, tmo);
        in_valid = 1'b0;
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL empty_timeout got %b want 0", tmo); end
        tests++; if (perm_log[bp % 8] !== 32'h8000_0000) begin fails++; $display("FAIL empty_perm_r got %h want 80000000", perm_log[bp % 8]); end
        tests++; if (r !== 32'h7FFF_FFFF) begin fails++; $display("FAIL empty_r_out got %h want 7fffffff", r); end
        tests++; if (c !== 320'd1) begin fails++; $display("FAIL empty_c_out got %0d want 1", c); end
        tests++; if (words_acc - bw !== 0) begin fails++; $display("FAIL empty_words got %0d want 0", words_acc - bw); end
        tests++; if (done_pulses - bd !== 1) begin fails++; $display("FAIL empty_pulses got %0d want 1", done_pulses - bd); end
        tests++; if (perm_rises - bp !== 1) begin fails++; $display("FAIL empty_perms got %0d want 1", perm_rises - bp); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL empty_latency got %0d want 5", lat); end
        tests++; if (absorb_done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL empty_after done=%b busy=%b want 0 0", absorb_done, busy); end
    endtask

    task automatic test_full_word();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int bp, bw;
        bp = perm_rises; bw = words_acc;
        do_msg(20'd32, 32'h1234_5678, 32'h0, 1, 0, 1'b0, r, c, lat, tmo);
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL full_timeout got %b want 0", tmo); end
        tests++; if (perm_log[bp % 8] !== 32'h1234_5678) begin fails++; $display("FAIL full_perm_r0 got %h want 12345678", perm_log[bp % 8]); end
        tests++; if (perm_log[(bp + 1) % 8] !== 32'h6DCB_A987) begin fails++; $display("FAIL full_perm_r1 got %h want 6dcba987", perm_log[(bp + 1) % 8]); end
        tests++; if (r !== 32'h9234_5678) begin fails++; $display("FAIL full_r_out got %h want 92345678", r); end
        tests++; if (c !== 320'd2) begin fails++; $display("FAIL full_c_out got %0d want 2", c); end
        tests++; if (words_acc - bw !== 1) begin fails++; $display("FAIL full_words got %0d want 1", words_acc - bw); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL full_latency got %0d want 9", lat); end
    endtask

    task automatic test_partial();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int bp, bw;
        bp = perm_rises; bw = words_acc;
        do_msg(20'd8, 32'hABFF_FFFF, 32'h0, 1, 0, 1'b0, r, c, lat, tmo);
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL partial_timeout got %b want 0", tmo); end
        tests++; if (perm_log[bp % 8] !== 32'hAB80_0000) begin fails++; $display("FAIL partial_perm_r got %h want ab800000", perm_log[bp % 8]); end
        tests++; if (r !== 32'h547F_FFFF) begin fails++; $display("FAIL partial_r_out got %h want 547fffff", r); end
        tests++; if (c !== 320'd1) begin fails++; $display("FAIL partial_c_out got %0d want 1", c); end
        tests++; if (words_acc - bw !== 1) begin fails++; $display("FAIL partial_words got %0d want 1", words_acc - bw); end
        tests++; if (perm_rises - bp !== 1) begin fails++; $display("FAIL partial_perms got %0d want 1", perm_rises - bp); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL partial_latency got %0d want 4", lat); end
    endtask

    task automatic test_gaps();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int bp, bw, brp, bu;
        bp = perm_rises; bw = words_acc; brp = ready_in_perm; bu = unstable;
        do_msg(20'd64, 32'h1111_1111, 32'h2222_2222, 2, 5, 1'b0, r, c, lat, tmo);
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL gaps_timeout got %b want 0", tmo); end
        tests++; if (perm_log[(bp + 1) % 8] !== 32'hCCCC_CCCC) begin fails++; $display("FAIL gaps_perm_r1 got %h want cccccccc", perm_log[(bp + 1) % 8]); end
        tests++; if (perm_log[(bp + 2) % 8] !== 32'hB333_3333) begin fails++; $display("FAIL gaps_perm_r2 got %h want b3333333", perm_log[(bp + 2) % 8]); end
        tests++; if (r !== 32'h4CCC_CCCC) begin fails++; $display("FAIL gaps_r_out got %h want 4ccccccc", r); end
        tests++; if (c !== 320'd3) begin fails++; $display("FAIL gaps_c_out got %0d want 3", c); end
        tests++; if (words_acc - bw !== 2) begin fails++; $display("FAIL gaps_words got %0d want 2", words_acc - bw); end
        tests++; if (perm_rises - bp !== 3) begin fails++; $display("FAIL gaps_perms got %0d want 3", perm_rises - bp); end
        tests++; if (ready_in_perm - brp !== 0) begin fails++; $display("FAIL gaps_ready_in_perm got %0d want 0", ready_in_perm - brp); end
        tests++; if (unstable - bu !== 0) begin fails++; $display("FAIL gaps_perm_r_stable got %0d want 0", unstable - bu); end
        repeat (5) @(posedge clk);
        #1;
        tests++; if (r_out !== 32'h4CCC_CCCC) begin fails++; $display("FAIL gaps_r_out_hold got %h want 4ccccccc", r_out); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int n;
        msg_len = 20'd32;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!perm_go && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++; if (perm_go !== 1'b1) begin fails++; $display("FAIL rmid_reach_permute got %b want 1", perm_go); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++; if (perm_go !== 1'b0) begin fails++; $display("FAIL rmid_perm_go got %b want 0", perm_go); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b want 0", busy); end
        tests++; if (in_ready !== 1'b0 || absorb_done !== 1'b0) begin fails++; $display("FAIL rmid_ready_done got %b %b want 0 0", in_ready, absorb_done); end
        tests++; if (r_out !== 32'd0 || c_out !== 320'd0) begin fails++; $display("FAIL rmid_outputs got %h %0d want 0 0", r_out, c_out); end
        do_msg(20'd32, 32'h1234_5678, 32'h0, 1, 0, 1'b0, r, c, lat, tmo);
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL rmid_timeout got %b want 0", tmo); end
        tests++; if (r !== 32'h9234_5678 || c !== 320'd2) begin fails++; $display("FAIL rmid_rerun got %h %0d want 92345678 2", r, c); end
    endtask

    task automatic test_busy_start();
        logic [31:0] r; logic [319:0] c; int lat; bit tmo;
        int bp, bd;
        bp = perm_rises; bd = done_pulses;
        do_msg(20'd32, 32'h1234_5678, 32'h0, 1, 3, 1'b1, r, c, lat, tmo);
        tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL busy_timeout got %b want 0", tmo); end
        tests++; if (r !== 32'h9234_5678) begin fails++; $display("FAIL busy_r_out got %h want 92345678", r); end
        tests++; if (c !== 320'd2) begin fails++; $display("FAIL busy_c_out got %0d want 2", c); end
        repeat (10) @(posedge clk);
        #1;
        tests++; if (perm_rises - bp !== 2) begin fails++; $display("FAIL busy_perms got %0d want 2", perm_rises - bp); end
        tests++; if (done_pulses - bd !== 1) begin fails++; $display("FAIL busy_pulses got %0d want 1", done_pulses - bd); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL busy_idle_after got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_full_word();
        test_partial();
        test_gaps();
        test_reset_mid();
        test_busy_start();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sponge_absorb.md
SPONGE_ABSORB -- requirements
Module: sponge_absorb

Interface
REQ-001 SHALL have parameter RWIDTH, default 32, meaning rate width in bits (one message word).
REQ-002 SHALL have parameter CWIDTH, default 320, meaning capacity width in bits.
REQ-003 SHALL have parameter LENWIDTH, default 20, meaning message-length counter width in bits.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin absorbing a new message; sampled only in IDLE.
REQ-007 SHALL have port msg_len  input  LENWIDTH  message length in bits; latched on accepted start.
REQ-008 SHALL have port in_valid  input  1  in_data holds a valid message word.
REQ-009 SHALL have port in_data  input  RWIDTH  message word, MSB-first; a partial final word is MSB-aligned.
REQ-010 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-011 SHALL have port perm_go  output  1  permutation request, level-held.
REQ-012 SHALL have port perm_r  output  RWIDTH  rate sent to the permutation.
REQ-013 SHALL have port perm_c  output  CWIDTH  capacity sent to the permutation.
REQ-014 SHALL have port perm_done  input  1  permutation result valid.
REQ-015 SHALL have port perm_rin  input  RWIDTH  permuted rate.
REQ-016 SHALL have port perm_cin  input  CWIDTH  permuted capacity.
REQ-017 SHALL have port r_out  output  RWIDTH  final rate for the squeeze stage.
REQ-018 SHALL have port c_out  output  CWIDTH  final capacity for the squeeze stage.
REQ-019 SHALL have port absorb_done  output  1  one-cycle pulse: r_out/c_out valid.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-021 SHALL implement states IDLE, ABSORB, PAD, PERMUTE, DONE.
REQ-022 IDLE: start=1 SHALL latch msg_len into rem, clear rate/capacity registers and final flag, and go to ABSORB (rem>0) or PAD (rem=0).
REQ-023 ABSORB: in_ready SHALL be 1; a word SHALL be accepted only on in_valid&in_ready; without in_valid the state holds.
REQ-024 Full word (rem>=RWIDTH): rate ^= in_data, rem -= RWIDTH, go to PERMUTE; next state after PERMUTE is ABSORB if new rem>0, else PAD.
REQ-025 Partial word (0<rem<RWIDTH): rate ^= (in_data with low RWIDTH-rem bits zeroed) | (1 << (RWIDTH-1-rem)), rem=0, final=1, go to PERMUTE.
REQ-026 PAD (length a multiple of RWIDTH, incl. 0): rate ^= 1<<(RWIDTH-1), final=1, go to PERMUTE; no input consumed; in_ready=0.
REQ-027 PERMUTE: perm_go SHALL be 1 and perm_r/perm_c SHALL equal the rate/capacity registers, held stable until perm_done is sampled 1.
REQ-028 On perm_done=1 the block SHALL load rate<=perm_rin and capacity<=perm_cin, deassert perm_go the next cycle, and go to DONE if final=1, else to ABSORB/PAD per REQ-024.
REQ-029 DONE: absorb_done=1 for exactly one cycle, r_out/c_out loaded from the rate/capacity registers, then IDLE.
REQ-030 r_out/c_out SHALL hold their values until the next absorb_done.
REQ-031 in_ready SHALL be 0 outside ABSORB; start SHALL be ignored while busy=1.
REQ-032 Latency per permutation SHALL be exactly one issue cycle plus the permutation's own latency; no extra bubbles.

Reset
REQ-033 On reset=1 at a clock edge the block SHALL enter IDLE and clear rem, final, rate, capacity, r_out and c_out to 0, regardless of current state.
REQ-034 After reset, in_ready, perm_go, absorb_done and busy SHALL be 0 in the following cycle, including when reset occurs mid-PERMUTE.

Verification
Stub permutation: done 3 cycles after perm_go rises; returns rin=perm_r^32'hFFFFFFFF, cin=perm_c+1.
REQ-035 msg_len=0, start -> no word accepted; perm_r=0x80000000; r_out=0x7FFFFFFF, c_out=1, one absorb_done pulse.
REQ-036 msg_len=32, word 0x12345678 -> first perm_r=0x12345678, second perm_r=0x6DCBA987; r_out=0x92345678, c_out=2.
REQ-037 msg_len=8, word 0xABFFFFFF -> perm_r=0xAB800000; r_out=0x547FFFFF, c_out=1; exactly one word accepted.
REQ-038 msg_len=64, in_valid with 5-cycle gaps -> in_ready=0 throughout PERMUTE; each word consumed once; three permutations, c_out=3.
REQ-039 Reset during PERMUTE of REQ-036 -> next cycle perm_go=0, busy=0, r_out=0; fresh start then reproduces REQ-036 results.
REQ-040 start pulsed while busy -> ignored; msg_len change mid-message has no effect on the result.
